// File: rtl/srgh_glitch_sched.sv
// S-RGH Trinity attempt sequencer: follows CPU POST progress, requests I2C
// slowdown/speedup, fires the reset glitch and reboots the console on failure.
module srgh_glitch_sched #(
  parameter int unsigned POST_SLOW     = 4,
  parameter int unsigned POST_GLITCH   = 6,
  parameter int unsigned GLITCH_DELAY  = 12,
  parameter int unsigned GLITCH_WIDTH  = 1,
  parameter int unsigned I2C_HOLD      = 8448,
  parameter int unsigned POST_OK       = 10,
  parameter int unsigned TIMEOUT       = 65535,
  parameter int unsigned REBOOT_CYCLES = 4000,
  parameter int unsigned MAX_ATTEMPTS  = 255
) (
  input  logic       clk_400k,
  input  logic       rst,
  input  logic       enable,
  input  logic       post_bit,
  output logic       i2c_send,
  output logic       glitch_rst,
  output logic       cpu_rst_hold,
  output logic       booted,
  output logic       gave_up,
  output logic [7:0] attempt_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    SLOW  = 3'd2,
    DELAY = 3'd3,
    PULSE = 3'd4,
    WATCH = 3'd5,
    FAIL  = 3'd6,
    DONE  = 3'd7
  } state_t;

  localparam int TW = 17;
  localparam int HW = 16;

  function automatic int unsigned minus1(input int unsigned v);
    return (v > 0) ? v - 1 : 0;
  endfunction

  // Counters count down to 0 inclusive, so loads are one less than the span.
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(minus1(TIMEOUT));
  localparam logic [TW-1:0] REBOOT_LOAD  = TW'(minus1(REBOOT_CYCLES));
  localparam logic [TW-1:0] DELAY_LOAD   = TW'(minus1(GLITCH_DELAY));
  localparam logic [HW-1:0] HOLD_LOAD    = HW'(minus1(I2C_HOLD));
  localparam logic [7:0]    WIDTH_LOAD   = 8'(minus1(GLITCH_WIDTH));
  localparam logic [7:0]    SLOW_EDGE    = 8'(POST_SLOW);
  localparam logic [7:0]    GLITCH_EDGE  = 8'(POST_GLITCH);
  localparam logic [7:0]    OK_EDGE      = 8'(POST_OK);
  localparam logic [7:0]    MAX_ATT      = 8'((MAX_ATTEMPTS > 255) ? 255 : MAX_ATTEMPTS);
  localparam bit            LIMITED      = (MAX_ATTEMPTS != 0);

  state_t          state;
  logic            sync1, sync2, post_prev;
  logic            post_edge, enter_arm;
  logic [7:0]      post_edges, edges_nxt;
  logic [TW-1:0]   timer;
  logic [HW-1:0]   hold_cnt;
  logic [7:0]      pulse_cnt;

  assign post_edge = sync2 ^ post_prev;
  assign edges_nxt = post_edges + {7'd0, post_edge && (post_edges != 8'hFF)};
  assign enter_arm = (state == IDLE) && enable && !booted && !gave_up;
  assign state_o   = state;

  // The FSM looks at edges_nxt so it reacts on the same clock the count lands.
  always_ff @(posedge clk_400k or posedge rst) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      post_prev  <= 1'b0;
      post_edges <= 8'd0;
    end else begin
      sync1     <= post_bit;
      sync2     <= sync1;
      post_prev <= sync2;
      if (enter_arm) post_edges <= 8'd0;
      else           post_edges <= edges_nxt;
    end
  end

  always_ff @(posedge clk_400k or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      i2c_send     <= 1'b0;
      glitch_rst   <= 1'b0;
      cpu_rst_hold <= 1'b0;
      booted       <= 1'b0;
      gave_up      <= 1'b0;
      attempt_cnt  <= 8'd0;
      timer        <= '0;
      hold_cnt     <= '0;
      pulse_cnt    <= 8'd0;
    end else begin
      if (hold_cnt != 0) hold_cnt <= hold_cnt - 1'b1;
      unique case (state)
        IDLE: begin
          if (enter_arm) begin
            state <= ARM;
            timer <= TIMEOUT_LOAD;
            if (attempt_cnt != 8'hFF) attempt_cnt <= attempt_cnt + 1'b1;
          end
        end
        ARM: begin
          if (timer != 0) timer <= timer - 1'b1;
          if (edges_nxt == SLOW_EDGE && hold_cnt == 0) begin
            i2c_send <= 1'b1;
            hold_cnt <= HOLD_LOAD;
            state    <= SLOW;
          end else if (timer == 0) begin
            state <= FAIL;
          end
        end
        SLOW: begin
          if (timer != 0) timer <= timer - 1'b1;
          if (edges_nxt == GLITCH_EDGE) begin
            timer <= DELAY_LOAD;
            state <= DELAY;
          end else if (timer == 0) begin
            state <= FAIL;
          end
        end
        DELAY: begin
          if (timer == 0) begin
            glitch_rst <= 1'b1;
            pulse_cnt  <= WIDTH_LOAD;
            state      <= PULSE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        PULSE: begin
          if (glitch_rst) begin
            if (pulse_cnt == 0) glitch_rst <= 1'b0;
            else                pulse_cnt  <= pulse_cnt - 1'b1;
          end else if (hold_cnt == 0) begin
            i2c_send <= 1'b0;
            hold_cnt <= HOLD_LOAD;
            timer    <= TIMEOUT_LOAD;
            state    <= WATCH;
          end
        end
        WATCH: begin
          // Success is tested first so a boot landing on expiry still counts.
          if (edges_nxt >= OK_EDGE) begin
            booted <= 1'b1;
            state  <= DONE;
          end else if (timer == 0) begin
            state <= FAIL;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        FAIL: begin
          if (cpu_rst_hold) begin
            if (timer == 0) begin
              cpu_rst_hold <= 1'b0;
              state        <= IDLE;
            end else begin
              timer <= timer - 1'b1;
            end
          end else if (hold_cnt == 0) begin
            if (i2c_send) begin
              i2c_send <= 1'b0;
              hold_cnt <= HOLD_LOAD;
            end
            if (LIMITED && attempt_cnt >= MAX_ATT) begin
              gave_up <= 1'b1;
              state   <= DONE;
            end else begin
              cpu_rst_hold <= 1'b1;
              timer        <= REBOOT_LOAD;
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/srgh_glitch_sched.md
Name: srgh_glitch_sched

Overview:
- Top-level attempt sequencer for the S-RGH Trinity glitch.
- Watches the CPU POST bus LSB to track boot progress.
- Drives the level-sensitive i2c_send request into the HANA I2C injector: 1 requests slowdown, 0 requests speedup.
- Fires the CPU reset glitch pulse, decides success or failure, and reboots the console for a retry until boot succeeds or the attempt budget runs out.

Parameters:
- POST_SLOW, 4: POST edge count at which slowdown is requested.
- POST_GLITCH, 6: POST edge count that starts the glitch delay.
- GLITCH_DELAY, 12: clocks from the POST_GLITCH edge to the start of the reset pulse.
- GLITCH_WIDTH, 1: reset pulse width in clocks. Minimum 1.
- I2C_HOLD, 8448: minimum clocks that i2c_send must hold a level before it may toggle. This covers one 256-bit message plus 32 delay passes.
- POST_OK, 10: POST edge count that declares success.
- TIMEOUT, 65535: clocks allowed in WATCH before failure.
- REBOOT_CYCLES, 4000: clocks that cpu_rst_hold is held during a retry.
- MAX_ATTEMPTS, 255: attempt budget. 0 means unlimited.

Ports:
- clk_400k, in, 1: the only clock, 400 kHz.
- rst, in, 1: asynchronous, active-high reset.
- enable, in, 1: arms the sequencer. Sampled only in IDLE.
- post_bit, in, 1: CPU POST LSB. Asynchronous to clk_400k.
- i2c_send, out, 1: request level for the I2C injector. 1 = slowdown, 0 = speedup.
- glitch_rst, out, 1: CPU reset glitch pulse, active-high.
- cpu_rst_hold, out, 1: long CPU reset used for reboot, active-high.
- booted, out, 1: sticky success flag.
- gave_up, out, 1: sticky flag set when the attempt budget is exhausted.
- attempt_cnt, out, 8: number of attempts started. Saturates at 255.
- state_o, out, 3: current state encoding, for debug LEDs.

Behaviour:
- Reset: every output is 0; state is IDLE; the edge counter, timers and synchroniser flops are 0. This applies asynchronously at any point in the sequence; any pulse in progress drops immediately.
- POST synchroniser and edge counter:
  - post_bit passes through a 2-flop synchroniser, then an XOR edge detect against the previous synchronised value. Both rising and falling edges count.
  - post_edges is 8 bits, saturating at 255.
  - It is cleared on entry to ARM.
  - Latency from a post_bit edge to the counter increment is 3 clocks.
- hold_cnt is loaded with I2C_HOLD whenever i2c_send changes and counts down to 0. It gates every transition that would toggle i2c_send.
- States and encoding:
  - IDLE (0): if enable=1 and neither booted nor gave_up is set, go to ARM. On that transition attempt_cnt increments.
  - ARM (1): when post_edges == POST_SLOW, set i2c_send=1 and go to SLOW.
  - SLOW (2): when post_edges == POST_GLITCH, load the delay timer with GLITCH_DELAY and go to DELAY.
  - DELAY (3): the timer counts to 0, then go to PULSE. glitch_rst rises on the clock after the timer reaches 0.
  - PULSE (4):
    - glitch_rst=1 for exactly GLITCH_WIDTH clocks, then drops to 0.
    - Once glitch_rst is low and hold_cnt==0, i2c_send goes to 0.
    - Then load the timer with TIMEOUT and go to WATCH.
  - WATCH (5):
    - If post_edges >= POST_OK, set booted=1 and go to DONE.
    - Otherwise, when the timer expires, go to FAIL.
    - If success and expiry happen on the same clock, success wins.
  - FAIL (6):
    - Requires hold_cnt==0 before acting.
    - If MAX_ATTEMPTS != 0 and attempt_cnt >= MAX_ATTEMPTS: set gave_up=1 and go to DONE.
    - Else: cpu_rst_hold=1 for REBOOT_CYCLES clocks, then 0, then go to IDLE.
  - DONE (7): terminal. Only rst leaves this state. i2c_send=0.
- enable deassertion outside IDLE has no effect; the current attempt runs to completion.
- If POST_SLOW is skipped because the counter jumps past it, ARM times out via the WATCH timer: a TIMEOUT timer also runs in ARM and SLOW, and expiry goes to FAIL.
- glitch_rst and cpu_rst_hold are never high on the same clock.
- i2c_send never toggles while hold_cnt != 0.

Test Plan:
- Nominal boot: enable=1; post_bit toggles 4, then 6, then 10 edges, each 20 clocks apart. Required response:
  - i2c_send rises 3 clocks after the 4th edge.
  - glitch_rst is high for 1 clock, starting 12+3 clocks after the 6th edge.
  - i2c_send falls once hold_cnt expires.
  - booted=1 after the 10th edge; attempt_cnt=1; state_o=7.
- Failure and retry: stop POST after 7 edges. Required response:
  - After 65535 clocks in WATCH, the state is FAIL.
  - cpu_rst_hold is high for exactly 4000 clocks.
  - The sequencer returns to IDLE, then ARM, with attempt_cnt=2.
- Budget exhaustion: MAX_ATTEMPTS=2, POST always stalls. Required response: after the 2nd FAIL, gave_up=1, state_o=7, and cpu_rst_hold does not fire a 3rd time.
- I2C hold: POST_GLITCH edge arrives 100 clocks after slowdown. Required response: glitch_rst fires on time, but i2c_send stays 1 until 8448 clocks after its rise.
- Async reset: assert rst in the middle of the glitch_rst pulse (GLITCH_WIDTH=4). Required response: glitch_rst, i2c_send and attempt_cnt are 0 within the same clock; state_o=0.
- Simultaneous events: the 10th edge and timer expiry land on the same clock. Required response: booted=1 and no FAIL.
